// File: rtl/apb_cmd_master.sv
// ----------------------------------------------------------------------------
// apb_cmd_master
//
// Turns a byte-oriented command stream (for example a host UART RX FIFO) into
// single APB transfers and returns a status/data response on a second byte
// stream (for example a host UART TX FIFO).
//
// Command frame : opcode (0x57 write / 0x52 read), 4 address bytes (LE),
//                 then 4 write-data bytes (LE) for writes only.
// Response      : status byte (0x00 ok, 0x01 slave error, 0x02 timeout,
//                 0xEE bad opcode), then 4 read-data bytes (LE) for reads.
//
// Ports
//   clk_i, rstn_i                      clock, async active-low reset
//   s_axis_tdata/tvalid/tready         command byte stream in
//   m_axis_tdata/tvalid/tready         response byte stream out
//   m_apb_paddr/psel/penable/pwrite/pwdata   APB request (registered)
//   m_apb_prdata/pready/pslverr        APB completer response
// ----------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [7:0]                m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [APB_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic                      m_apb_psel,
    output logic                      m_apb_penable,
    output logic                      m_apb_pwrite,
    output logic [APB_DATA_WIDTH-1:0] m_apb_pwdata,
    input  logic [APB_DATA_WIDTH-1:0] m_apb_prdata,
    input  logic                      m_apb_pready,
    input  logic                      m_apb_pslverr
);

    // Timeout counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TCW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_SLVERR   = 8'h01;
    localparam logic [7:0] ST_TIMEOUT  = 8'h02;
    localparam logic [7:0] ST_BADOP    = 8'hEE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        SETUP  = 3'd3,
        ACCESS = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t                    state_r;
    logic [2:0]                byte_cnt_r;
    logic [TCW-1:0]            tmo_cnt_r;
    logic [31:0]               addr_r;
    logic [APB_DATA_WIDTH-1:0] wdata_r;
    logic [APB_DATA_WIDTH-1:0] rdata_r;
    logic                      is_write_r;
    logic                      resp_long_r;
    logic                      tready_r;
    logic                      tvalid_r;
    logic [7:0]                tdata_r;
    logic                      psel_r;
    logic                      penable_r;
    logic                      pwrite_r;

    logic                      s_hs_s;
    logic                      m_hs_s;

    assign s_hs_s = s_axis_tvalid & tready_r;
    assign m_hs_s = tvalid_r & m_axis_tready;

    assign s_axis_tready = tready_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_apb_psel    = psel_r;
    assign m_apb_penable = penable_r;
    assign m_apb_pwrite  = pwrite_r;
    assign m_apb_pwdata  = wdata_r;

    // The frame always carries 32 address bits; fit them to the bus width.
    generate
        if (APB_ADDR_WIDTH > 32) begin : g_addr_wide
            assign m_apb_paddr = {{(APB_ADDR_WIDTH-32){1'b0}}, addr_r};
        end else begin : g_addr_narrow
            assign m_apb_paddr = addr_r[APB_ADDR_WIDTH-1:0];
        end
    endgenerate

    // Command/APB/response sequencer with all outputs registered.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r     <= IDLE;
            byte_cnt_r  <= 3'd0;
            tmo_cnt_r   <= '0;
            addr_r      <= 32'd0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            is_write_r  <= 1'b0;
            resp_long_r <= 1'b0;
            tready_r    <= 1'b0;
            tvalid_r    <= 1'b0;
            tdata_r     <= 8'd0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tready_r <= 1'b1;
                    if (s_hs_s) begin
                        byte_cnt_r <= 3'd0;
                        if ((s_axis_tdata == OP_WRITE) || (s_axis_tdata == OP_READ)) begin
                            is_write_r <= (s_axis_tdata == OP_WRITE);
                            state_r    <= ADDR;
                        end else begin
                            // Unknown opcode: answer immediately, no bus cycle.
                            tready_r    <= 1'b0;
                            tvalid_r    <= 1'b1;
                            tdata_r     <= ST_BADOP;
                            resp_long_r <= 1'b0;
                            state_r     <= RESP;
                        end
                    end
                end

                ADDR: begin
                    if (s_hs_s) begin
                        // Little-endian: each new byte enters at the top.
                        addr_r <= {s_axis_tdata, addr_r[31:8]};
                        if (byte_cnt_r == 3'd3) begin
                            byte_cnt_r <= 3'd0;
                            if (is_write_r) begin
                                state_r <= DATA;
                            end else begin
                                tready_r  <= 1'b0;
                                psel_r    <= 1'b1;
                                penable_r <= 1'b0;
                                pwrite_r  <= 1'b0;
                                state_r   <= SETUP;
                            end
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 3'd1;
                        end
                    end
                end

                DATA: begin
                    if (s_hs_s) begin
                        wdata_r <= {s_axis_tdata, wdata_r[APB_DATA_WIDTH-1:8]};
                        if (byte_cnt_r == 3'd3) begin
                            byte_cnt_r <= 3'd0;
                            tready_r   <= 1'b0;
                            psel_r     <= 1'b1;
                            penable_r  <= 1'b0;
                            pwrite_r   <= 1'b1;
                            state_r    <= SETUP;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 3'd1;
                        end
                    end
                end

                SETUP: begin
                    penable_r <= 1'b1;
                    tmo_cnt_r <= '0;
                    state_r   <= ACCESS;
                end

                ACCESS: begin
                    if (m_apb_pready) begin
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        tdata_r     <= m_apb_pslverr ? ST_SLVERR : ST_OK;
                        tvalid_r    <= 1'b1;
                        resp_long_r <= ~is_write_r;
                        byte_cnt_r  <= 3'd0;
                        state_r     <= RESP;
                        if (!is_write_r) begin
                            rdata_r <= m_apb_prdata;
                        end
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        // Completer never answered: abort with zeroed read data.
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        tdata_r     <= ST_TIMEOUT;
                        tvalid_r    <= 1'b1;
                        resp_long_r <= ~is_write_r;
                        rdata_r     <= '0;
                        byte_cnt_r  <= 3'd0;
                        state_r     <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 1'b1;
                    end
                end

                RESP: begin
                    if (m_hs_s) begin
                        // byte_cnt_r counts response bytes already accepted.
                        if (!resp_long_r || (byte_cnt_r == 3'd4)) begin
                            tvalid_r   <= 1'b0;
                            tready_r   <= 1'b1;
                            byte_cnt_r <= 3'd0;
                            state_r    <= IDLE;
                        end else begin
                            tdata_r    <= rdata_r[{byte_cnt_r[1:0], 3'b000} +: 8];
                            byte_cnt_r <= byte_cnt_r + 3'd1;
                        end
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    byte_cnt_r <= 3'd0;
                    tready_r   <= 1'b0;
                    tvalid_r   <= 1'b0;
                    psel_r     <= 1'b0;
                    penable_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// ----------------------------------------------------------------------------
// Self-checking bench for apb_cmd_master.
// A frame-level model predicts the APB transfer (address, direction, data,
// number of penable cycles) and the response bytes; a negedge monitor checks
// the DUT against it every cycle, and each scenario also pins a literal.
// ----------------------------------------------------------------------------
module tb_apb_cmd_master;

    localparam int T = 16;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_apb_paddr;
    logic        m_apb_psel;
    logic        m_apb_penable;
    logic        m_apb_pwrite;
    logic [31:0] m_apb_pwdata;
    logic [31:0] m_apb_prdata = 32'd0;
    logic        m_apb_pready = 1'b0;
    logic        m_apb_pslverr = 1'b0;

    always #5 clk_i = ~clk_i;

    apb_cmd_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_apb_paddr  (m_apb_paddr),
        .m_apb_psel   (m_apb_psel),
        .m_apb_penable(m_apb_penable),
        .m_apb_pwrite (m_apb_pwrite),
        .m_apb_pwdata (m_apb_pwdata),
        .m_apb_prdata (m_apb_prdata),
        .m_apb_pready (m_apb_pready),
        .m_apb_pslverr(m_apb_pslverr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- completer / sink configuration ----------------
    int          cfg_wait  = 0;      // ACCESS cycles with pready=0; <0 means never ready
    logic        cfg_err   = 1'b0;
    logic [31:0] cfg_rdata = 32'd0;
    logic        noise_en  = 1'b0;   // drive pready/pslverr high outside ACCESS
    logic        bp_en     = 1'b0;
    logic [3:0]  bp_pat    = 4'b1001;
    int          bp_idx    = 0;
    int          acc       = 0;

    // APB completer and response-stream sink, driven 1 time unit after posedge.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (m_apb_psel && m_apb_penable) begin
                acc++;
                m_apb_pready  = (cfg_wait >= 0) && (acc > cfg_wait);
                m_apb_pslverr = cfg_err;
                m_apb_prdata  = cfg_rdata;
            end else begin
                acc = 0;
                m_apb_pready  = noise_en;
                m_apb_pslverr = noise_en;
                m_apb_prdata  = noise_en ? 32'hFFFF_FFFF : 32'h0000_0000;
            end
            if (m_axis_tvalid && bp_en) begin
                m_axis_tready = bp_pat[bp_idx % 4];
                bp_idx++;
            end else begin
                m_axis_tready = 1'b1;
            end
        end
    end

    // ---------------- frame-level model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          pen;
    } apb_t;

    apb_t        exp_apb[$];
    logic [7:0]  exp_resp[$];
    logic        frame_done = 1'b1;
    logic [39:0] got_pack = 40'd0;
    int          got_n = 0;
    int          last_pen = 0;

    task automatic expect_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd);
        apb_t        t;
        logic        tmo;
        logic [7:0]  st;
        logic [31:0] rd;
        if ((op == 8'h57) || (op == 8'h52)) begin
            tmo = (cfg_wait < 0) || (cfg_wait >= T);
            t.addr  = addr;
            t.wr    = (op == 8'h57);
            t.wdata = wd;
            t.pen   = tmo ? T : cfg_wait + 1;
            exp_apb.push_back(t);
            st = tmo ? 8'h02 : (cfg_err ? 8'h01 : 8'h00);
            rd = tmo ? 32'd0 : cfg_rdata;
            exp_resp.push_back(st);
            if (!t.wr) begin
                for (int i = 0; i < 4; i++) exp_resp.push_back(rd[8*i +: 8]);
            end
        end else begin
            exp_resp.push_back(8'hEE);
        end
    endtask

    // ---------------- stream driver (called at posedge+1) ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic hs;
        int   k;
        s_axis_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk_i);
            #1;
        end
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        k = 0;
        forever begin
            @(negedge clk_i);
            hs = s_axis_tready;
            @(posedge clk_i);
            if (hs) break;
            k++;
            if (k > 500) begin
                chk("s_handshake_timeout", s_axis_tready, 1);
                break;
            end
        end
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] wd, input int max_gap);
        logic [7:0] q[$];
        q.push_back(op);
        if ((op == 8'h57) || (op == 8'h52)) begin
            for (int i = 0; i < 4; i++) q.push_back(addr[8*i +: 8]);
        end
        if (op == 8'h57) begin
            for (int i = 0; i < 4; i++) q.push_back(wd[8*i +: 8]);
        end
        frame_done = 1'b0;
        foreach (q[i]) send_byte(q[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        frame_done = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (((exp_resp.size() != 0) || (exp_apb.size() != 0)) && (k < 3000)) begin
            @(posedge clk_i);
            k++;
        end
        chk("resp_pending", exp_resp.size(), 0);
        chk("apb_pending", exp_apb.size(), 0);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic check_lit(input string name, input int n, input logic [39:0] exp);
        chk({name, "_len"}, got_n, n);
        chk(name, got_pack, exp);
        got_n    = 0;
        got_pack = 40'd0;
    endtask

    // ---------------- cycle monitor ----------------
    logic       prev_psel  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_tdata = 8'd0;
    int         pen_cnt    = 0;

    // Checks APB, both streams and the model queues on every falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                prev_psel  = 1'b0;
                prev_stall = 1'b0;
                pen_cnt    = 0;
            end else begin
                if (m_apb_psel) begin
                    chk("apb_after_frame", frame_done, 1);
                    if (exp_apb.size() == 0) begin
                        chk("unexpected_psel", m_apb_psel, 0);
                    end else begin
                        chk("paddr", m_apb_paddr, exp_apb[0].addr);
                        chk("pwrite", m_apb_pwrite, exp_apb[0].wr);
                        if (exp_apb[0].wr) chk("pwdata", m_apb_pwdata, exp_apb[0].wdata);
                    end
                    if (!prev_psel) chk("setup_penable", m_apb_penable, 0);
                    else            chk("access_penable", m_apb_penable, 1);
                    if (m_apb_penable) pen_cnt++;
                end else begin
                    chk("penable_no_psel", m_apb_penable, 0);
                    if (prev_psel) begin
                        if (exp_apb.size() != 0) begin
                            chk("access_len", pen_cnt, exp_apb[0].pen);
                            void'(exp_apb.pop_front());
                        end
                        last_pen = pen_cnt;
                        pen_cnt  = 0;
                    end
                end
                if (m_apb_psel || m_axis_tvalid) chk("tready_busy", s_axis_tready, 0);
                if (prev_stall) begin
                    chk("tvalid_hold", m_axis_tvalid, 1);
                    chk("tdata_hold", m_axis_tdata, prev_tdata);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_resp.size() == 0) begin
                        chk("unexpected_resp", m_axis_tvalid, 0);
                    end else begin
                        chk("resp_byte", m_axis_tdata, exp_resp[0]);
                        void'(exp_resp.pop_front());
                    end
                    got_pack = {got_pack[31:0], m_axis_tdata};
                    got_n++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_tdata = m_axis_tdata;
                prev_psel  = m_apb_psel;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_psel", m_apb_psel, 0);
        chk("rst_penable", m_apb_penable, 0);
        chk("rst_pwrite", m_apb_pwrite, 0);
        chk("rst_paddr", m_apb_paddr, 0);
        chk("rst_pwdata", m_apb_pwdata, 0);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("tready_before_edge", s_axis_tready, 0);
        @(negedge clk_i);
        chk("tready_after_edge", s_axis_tready, 1);
        @(posedge clk_i);
        #1;

        // Write, ready on first ACCESS cycle, noisy pready outside ACCESS
        cfg_wait = 0; cfg_err = 1'b0; noise_en = 1'b1;
        expect_frame(8'h57, 32'h0000_0008, 32'h0000_0001);
        send_frame(8'h57, 32'h0000_0008, 32'h0000_0001, 0);
        wait_idle();
        check_lit("wr_resp", 1, 40'h00_0000_0000);
        chk("wr_pen_cycles", last_pen, 1);

        // Read with three wait states
        cfg_wait = 3; cfg_rdata = 32'h0000_00A5;
        expect_frame(8'h52, 32'h0000_0004, 32'h0);
        send_frame(8'h52, 32'h0000_0004, 32'h0, 0);
        wait_idle();
        check_lit("rd_resp", 5, 40'h00_A5_00_00_00);
        chk("rd_pen_cycles", last_pen, 4);
        noise_en = 1'b0;

        // Timeout on a read
        cfg_wait = -1;
        expect_frame(8'h52, 32'h0000_0010, 32'h0);
        send_frame(8'h52, 32'h0000_0010, 32'h0, 0);
        wait_idle();
        check_lit("tmo_resp", 5, 40'h02_00_00_00_00);
        chk("tmo_pen_cycles", last_pen, T);

        // Slave error on a write
        cfg_wait = 1; cfg_err = 1'b1;
        expect_frame(8'h57, 32'h0000_0020, 32'hCAFE_F00D);
        send_frame(8'h57, 32'h0000_0020, 32'hCAFE_F00D, 0);
        wait_idle();
        check_lit("slverr_resp", 1, 40'h00_0000_0001);
        cfg_err = 1'b0;

        // Bad opcode: no APB activity (monitor flags any psel)
        expect_frame(8'h41, 32'h0, 32'h0);
        send_frame(8'h41, 32'h0, 32'h0, 0);
        wait_idle();
        check_lit("badop_resp", 1, 40'h00_0000_00EE);

        // Backpressure on the response plus input gaps
        cfg_wait = 0; cfg_rdata = 32'hDEAD_BEEF; bp_en = 1'b1; bp_idx = 0;
        expect_frame(8'h52, 32'h1234_5678, 32'h0);
        send_frame(8'h52, 32'h1234_5678, 32'h0, 3);
        wait_idle();
        check_lit("bp_resp", 5, 40'h00_EF_BE_AD_DE);
        bp_en = 1'b0;

        // Gapped write with a distinct data pattern
        cfg_wait = 2;
        expect_frame(8'h57, 32'hA5A5_0F0F, 32'h8765_4321);
        send_frame(8'h57, 32'hA5A5_0F0F, 32'h8765_4321, 2);
        wait_idle();
        check_lit("gap_wr_resp", 1, 40'h00_0000_0000);

        // Reset during ACCESS
        cfg_wait = -1;
        expect_frame(8'h52, 32'h0000_0044, 32'h0);
        send_frame(8'h52, 32'h0000_0044, 32'h0, 0);
        k = 0;
        while (!m_apb_penable && (k < 50)) begin
            @(negedge clk_i);
            k++;
        end
        chk("reach_access", m_apb_penable, 1);
        @(posedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("arst_psel", m_apb_psel, 0);
        chk("arst_penable", m_apb_penable, 0);
        exp_apb.delete();
        exp_resp.delete();
        got_n = 0;
        got_pack = 40'd0;
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rel_tready_before_edge", s_axis_tready, 0);
        @(negedge clk_i);
        chk("rel_tready", s_axis_tready, 1);
        chk("rel_tvalid", m_axis_tvalid, 0);
        @(posedge clk_i);
        #1;
        cfg_wait = 0;
        expect_frame(8'h57, 32'h0000_0008, 32'h0000_0002);
        send_frame(8'h57, 32'h0000_0008, 32'h0000_0002, 1);
        wait_idle();
        check_lit("post_rst_resp", 1, 40'h00_0000_0000);
        chk("post_rst_pen", last_pen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
